// File: rtl/gpio_logic_combiner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gpio_logic_combiner_if                                    |
// | Brief    : GPIO channel inputs, reduction controls and combined      |
// |            result of gpio_logic_combiner.                            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface gpio_logic_combiner_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] gpio_in;
  logic [1:0]          mode;
  logic [CHANNELS-1:0] mask;
  logic                y;
  logic                y_valid;
  logic                change;

  modport master (
    output gpio_in,
    output mode,
    output mask,
    input  y,
    input  y_valid,
    input  change
  );

  modport slave (
    input  gpio_in,
    input  mode,
    input  mask,
    output y,
    output y_valid,
    output change
  );
endinterface
`default_nettype wire

// File: rtl/gpio_logic_combiner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gpio_logic_combiner                                       |
// | Brief    : Synchronises N GPIO channels, optionally glitch-filters   |
// |            them (GPIO_COMB_FILTER_EN), then masks and reduces them   |
// |            with a selectable NOR/OR/AND/XOR into a registered output.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module gpio_logic_combiner #(
  parameter int CHANNELS      = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  wire                  clk,
  input  wire                  rst_n,
  gpio_logic_combiner_if.slave bus
);

  localparam logic [1:0] c_mode_nor = 2'b00;
  localparam logic [1:0] c_mode_or  = 2'b01;
  localparam logic [1:0] c_mode_and = 2'b10;
  localparam logic [1:0] c_mode_xor = 2'b11;

`ifdef GPIO_COMB_FILTER_EN
  localparam int c_warm_cycles = FILTER_CYCLES + 3;
`else
  localparam int c_warm_cycles = 3;
`endif
  localparam int                  c_warm_w   = $clog2(c_warm_cycles + 1);
  localparam logic [c_warm_w-1:0] c_warm_max = c_warm_w'(c_warm_cycles);

  if (CHANNELS < 1 || CHANNELS > 32 || FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_param_check
    $error("gpio_logic_combiner: CHANNELS or FILTER_CYCLES out of range");
  end

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] w_filt;
  logic [CHANNELS-1:0] w_masked;
  logic [CHANNELS-1:0] w_and_in;
  logic                w_r;
  logic [c_warm_w-1:0] r_warm;
  logic [c_warm_w-1:0] w_warm_next;
  logic                r_y;
  logic                r_y_valid;
  logic                r_change;

  // GPIO_IN comes from another clock domain: two-flop synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.gpio_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_COMB_FILTER_EN
  localparam int                 c_cnt_w    = $clog2(FILTER_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_CYCLES - 1);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_filter
    logic               r_f;
    logic [c_cnt_w-1:0] r_cnt;

    // Any reversion to the accepted level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_f   <= 1'b0;
        r_cnt <= '0;
      end else if (r_sync2[gi] == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_f   <= r_sync2[gi];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end

    assign w_filt[gi] = r_f;
  end
`else
  assign w_filt = r_sync2;
`endif

  // Masked-off channels drive the identity element of the chosen reduction.
  assign w_masked = w_filt & bus.mask;
  assign w_and_in = w_filt | ~bus.mask;

  always_comb begin
    w_r = 1'b0;
    case (bus.mode)
      c_mode_nor: w_r = ~(|w_masked);
      c_mode_or:  w_r = |w_masked;
      c_mode_and: w_r = &w_and_in;
      c_mode_xor: w_r = ^w_masked;
      default:    w_r = 1'b0;
    endcase
  end

  assign w_warm_next = (r_warm == c_warm_max) ? r_warm : r_warm + c_warm_w'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm    <= '0;
      r_y_valid <= 1'b0;
      r_y       <= 1'b0;
      r_change  <= 1'b0;
    end else begin
      r_warm    <= w_warm_next;
      r_y_valid <= (w_warm_next == c_warm_max);
      r_y       <= w_r;
      // Gated by the pre-edge valid so the first load of Y never pulses.
      r_change  <= r_y_valid & (w_r != r_y);
    end
  end

  assign bus.y       = r_y;
  assign bus.y_valid = r_y_valid;
  assign bus.change  = r_change;

endmodule
`default_nettype wire

// File: doc/gpio_logic_combiner.md
# gpio_logic_combiner

Parametrised fabric block that combines N MSS GPIO outputs (GPIO_x_M2F) into a single logic output, replacing the fixed two-input NOR gate used so far. Each channel is synchronised into the fabric clock domain and optionally glitch-filtered. The channels are then masked and reduced with a run-time-selectable function (NOR/OR/AND/XOR), and the result is registered. The block sits between system_sb and the top-level output pin.

## Interface
- CHANNELS, 2: number of GPIO inputs; legal 1..32.
- FILTER_CYCLES, 4: consecutive stable cycles required before a channel change is accepted; legal 1..255. Counter width is $clog2(FILTER_CYCLES+1).
- CLK  input  1  fabric clock, e.g. FAB_CCC_GL0; all logic on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset, e.g. POWER_ON_RESET_N.
- GPIO_IN  input  CHANNELS  MSS GPIO outputs; treated as asynchronous.
- MODE  input  2  reduction select, synchronous to CLK: 00 NOR, 01 OR, 10 AND, 11 XOR.
- MASK  input  CHANNELS  per-channel enable (1 = included), synchronous to CLK.
- Y  output  1  registered combined result.
- Y_VALID  output  1  high once the warm-up period after reset has completed.
- CHANGE  output  1  one-cycle pulse when Y toggles while Y_VALID = 1.

## Operation
- Synchroniser: 2-flop chain per channel, reset to 0; output s[i].
- Filter (per channel): filtered bit f[i] and counter cnt[i], both reset to 0.
  - If s[i] == f[i], then cnt[i] <= 0.
  - Else if cnt[i] == FILTER_CYCLES-1, then f[i] <= s[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Effect: a change must persist for FILTER_CYCLES sampled cycles, and any reversion restarts the count.
- Masking: masked-off channels contribute the identity element: 0 for OR, NOR and XOR; 1 for AND.
- Reduction: r = OR(m) for OR; ~OR(m) for NOR; AND(m) for AND; XOR(m) for XOR.
- MASK = all zeros gives: OR = 0, NOR = 1, AND = 1, XOR = 0.
- Output register: Y <= r every cycle; reset value 0.
- Warm-up counter: reset to 0 and counts up to W, then saturates. Y_VALID <= (count == W).
  - W = FILTER_CYCLES+3 with the filter compiled in; W = 3 without it.
  - Y_VALID reset value 0.
- CHANGE: CHANGE <= Y_VALID & (r != Y); reset value 0. It is never asserted while Y_VALID = 0, including the first Y load.
- MODE and MASK changes affect r combinationally, so Y reflects them on the next edge; CHANGE pulses if Y toggles.
- Reset mid-operation (RESET_N low at any time): all flops clear immediately. Y = 0, Y_VALID = 0, CHANGE = 0, and any in-flight filter counts are discarded.

## Timing
- GPIO_IN edge to s[i]: 2 edges.
- s[i] to f[i]: FILTER_CYCLES edges.
- f[i] to Y: 1 edge. CHANGE asserts on the same edge as Y.
- Total input-to-Y latency: FILTER_CYCLES+3 edges (7 at default). Without the filter: 3 edges.
- A pulse on s[i] shorter than FILTER_CYCLES cycles is rejected; one of exactly FILTER_CYCLES cycles is accepted.
- Simultaneous channel changes are filtered independently, so Y may step through intermediate values; CHANGE pulses at each step.
- Y_VALID rises on edge W after RESET_N deasserts and stays high until the next reset.

## Configuration
- GPIO_COMB_FILTER_EN defined: per-channel glitch filter present as described; W = FILTER_CYCLES+3.
- GPIO_COMB_FILTER_EN undefined: no counters or f registers; f[i] = s[i] combinationally; FILTER_CYCLES is ignored; latency 3; W = 3.

## Test plan
- Reset values: hold RESET_N low with random inputs, then release with GPIO_IN = 00 and MODE = 00.
  - Y = 0, Y_VALID = 0 and CHANGE = 0 during reset.
  - Y_VALID rises on edge 7 after release (CHANNELS = 2, FILTER_CYCLES = 4), with Y = 1 and no CHANGE pulse.
- Legacy NOR equivalence: CHANNELS = 2, MODE = 00, MASK = 11, after warm-up.
  - GPIO_IN 00 -> 01: Y goes 1 -> 0 exactly 7 edges later, with a single-cycle CHANGE pulse.
  - 01 -> 11: Y stays 0, no CHANGE.
  - 11 -> 00: Y goes back to 1 after 7 edges.
- Glitch rejection: FILTER_CYCLES = 4, GPIO_IN[0] high for 3 cycles -> Y and CHANGE unchanged. The same pulse held 4 cycles -> Y toggles.
- Mode and mask: CHANNELS = 4, GPIO_IN = 0011, MASK = 0011 held stable.
  - AND -> 1; OR -> 1; NOR -> 0; XOR -> 0.
  - Set MASK = 0001 in XOR mode -> Y = 1 on the next edge with CHANGE.
  - Set MASK = 0000 in AND mode -> Y = 1.
- Reset mid-filter: start a channel change, assert RESET_N at cnt = 2 -> Y, Y_VALID and CHANGE go to 0 immediately. After release, the warm-up restarts from 0.
- Macro off: build without GPIO_COMB_FILTER_EN.
  - Y_VALID rises on edge 3.
  - An input change reaches Y in 3 edges.
  - A 1-cycle pulse propagates to Y as a 1-cycle pulse.
